// File: rtl/cannon_block_matmul.sv
// cannon_block_matmul
//   Cannon-algorithm N x N integer matrix multiplier, OUT = A x B. The
//   matrices are split over a SQRT_P x SQRT_P grid of BS x BS blocks
//   (BS = N/SQRT_P). Each MAC cycle multiplies every co-located block pair
//   and accumulates. Each SHIFT cycle rotates the A blocks left one block
//   column and the B blocks up one block row.
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; aborts any job in flight
//   start      job request, accepted only while ready=1
//   matrix_A   N*N elements of DW bits, row-major, sampled at acceptance
//   matrix_B   same layout as matrix_A
//   ready      high only in IDLE
//   out        N*N elements of ACC_W bits, row-major; qualified by out_valid
//   out_valid  result available, held until out_ack
//   out_ack    consumer acknowledge, ignored unless out_valid=1
module cannon_block_matmul #(
  parameter int N      = 4,
  parameter int SQRT_P = 2,
  parameter int DW     = 32,
  parameter int ACC_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DW*N*N-1:0]       matrix_A,
  input  logic [DW*N*N-1:0]       matrix_B,
  output logic                    ready,
  output logic [ACC_W*N*N-1:0]    out,
  output logic                    out_valid,
  input  logic                    out_ack
);

  localparam int BS = N / SQRT_P;
  localparam int RW = (SQRT_P > 1) ? $clog2(SQRT_P) : 1;

  if (N % SQRT_P != 0) begin : g_bad_cfg
    $error("cannon_block_matmul: N must be a multiple of SQRT_P");
  end

  typedef enum logic [1:0] {IDLE, MAC, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        round_q, round_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_W*N*N-1:0] out_q, out_d;
  logic [ACC_W-1:0]     acc_q [N][N];
  logic [ACC_W-1:0]     acc_d [N][N];
  logic [DW-1:0]        a_q   [N][N];
  logic [DW-1:0]        a_d   [N][N];
  logic [DW-1:0]        b_q   [N][N];
  logic [DW-1:0]        b_d   [N][N];

  // Full DW x DW product, then keep the low ACC_W bits (zero-extended when
  // ACC_W is wider than the product).
  function automatic logic [ACC_W-1:0] mul_trunc(input logic [DW-1:0] x,
                                                 input logic [DW-1:0] y);
    logic [2*DW-1:0]       p;
    logic [ACC_W+2*DW-1:0] w;
    p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
    w = {{ACC_W{1'b0}}, p};
    return w[ACC_W-1:0];
  endfunction

  always_comb begin
    int blk_i, blk_j, src;
    logic [ACC_W-1:0] sum;
    state_d     = state_q;
    round_d     = round_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    blk_i       = 0;
    blk_j       = 0;
    src         = 0;
    sum         = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Initial skew: block (i,j) of A takes A block (i,(i+j) mod P),
          // block (i,j) of B takes B block ((i+j) mod P, j).
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              blk_i = r / BS;
              blk_j = c / BS;
              src   = ((blk_i + blk_j) % SQRT_P) * BS;
              a_d[r][c]   = matrix_A[(r*N + src + (c % BS))*DW +: DW];
              b_d[r][c]   = matrix_B[((src + (r % BS))*N + c)*DW +: DW];
              acc_d[r][c] = '0;
            end
          end
          round_d = '0;
          state_d = MAC;
        end
      end

      MAC: begin
        // Element (r,c) lives in block (r/BS, c/BS); its block-local dot
        // product walks row r of the A block and column c of the B block.
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            sum = acc_q[r][c];
            for (int k = 0; k < BS; k++) begin
              sum = sum + mul_trunc(a_q[r][(c/BS)*BS + k], b_q[(r/BS)*BS + k][c]);
            end
            acc_d[r][c] = sum;
            out_d[(r*N + c)*ACC_W +: ACC_W] = (round_q == RW'(SQRT_P-1)) ?
                sum : out_q[(r*N + c)*ACC_W +: ACC_W];
          end
        end
        state_d = (round_q == RW'(SQRT_P-1)) ? DONE : SHIFT;
      end

      SHIFT: begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            a_d[r][c] = a_q[r][(c + BS) % N];
            b_d[r][c] = b_q[(r + BS) % N][c];
          end
        end
        round_d = round_q + 1'b1;
        state_d = MAC;
      end

      DONE: begin
        // out_valid rises one cycle after entering DONE, so an ack can only
        // be seen once the result has been presented.
        if (out_valid_q && out_ack) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      round_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          acc_q[r][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      acc_q       <= acc_d;
    end
  end

  // Operand block registers carry data only; their content is don't-care
  // until the next accepted start reloads them.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign ready     = (state_q == IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cannon_block_matmul.sv
// tb_cannon_block_matmul
//   Bench for cannon_block_matmul over five configurations (N,SQRT_P):
//   (2,2) (4,2) (2,1) (4,4) (6,3), all with 32-bit elements and accumulators.
//   Expected results come from a plain row-by-column matrix product.
module tb_cannon_block_matmul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cfg_n(input int g);
    case (g)
      0: return 2;
      1: return 4;
      2: return 2;
      3: return 4;
      default: return 6;
    endcase
  endfunction

  function automatic int cfg_s(input int g);
    case (g)
      0: return 2;
      1: return 2;
      2: return 1;
      3: return 4;
      default: return 3;
    endcase
  endfunction

  for (genvar g = 0; g < 5; g++) begin : cfg
    localparam int N  = cfg_n(g);
    localparam int S  = cfg_s(g);
    localparam int NN = N * N;

    logic              reset   = 1'b1;
    logic              start   = 1'b0;
    logic              out_ack = 1'b0;
    logic [32*NN-1:0]  ma      = '0;
    logic [32*NN-1:0]  mb      = '0;
    logic              ready;
    logic              out_valid;
    logic [32*NN-1:0]  res;
    logic [31:0]       ea [NN];
    logic [31:0]       eb [NN];
    logic [31:0]       ex [NN];

    cannon_block_matmul #(.N(N), .SQRT_P(S), .DW(32), .ACC_W(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .matrix_A (ma),
      .matrix_B (mb),
      .ready    (ready),
      .out      (res),
      .out_valid(out_valid),
      .out_ack  (out_ack)
    );

    // mode 0 random, 2 identity x 1..NN, 3 A=B={1,0,1,1}, 4 all-ones x 2
    task automatic set_mats(input int mode);
      logic [31:0] acc;
      for (int i = 0; i < NN; i++) begin
        case (mode)
          2: begin
            ea[i] = (i / N == i % N) ? 32'd1 : 32'd0;
            eb[i] = 32'(i + 1);
          end
          3: begin
            ea[i] = (i == 1) ? 32'd0 : 32'd1;
            eb[i] = ea[i];
          end
          4: begin
            ea[i] = 32'hFFFF_FFFF;
            eb[i] = 32'd2;
          end
          default: begin
            ea[i] = $urandom();
            eb[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
          end
        endcase
        ma[i*32 +: 32] = ea[i];
        mb[i*32 +: 32] = eb[i];
      end
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          acc = 32'd0;
          for (int k = 0; k < N; k++) acc = acc + ea[r*N + k] * eb[k*N + c];
          ex[r*N + c] = acc;
        end
      end
    endtask

    task automatic check_result(input string name);
      for (int i = 0; i < NN; i++)
        check_val($sformatf("cfg%0d_%s[%0d]", g, name, i), 64'(res[i*32 +: 32]), 64'(ex[i]));
    endtask

    task automatic check_cleared(input string name);
      check_val($sformatf("cfg%0d_%s_ready", g, name), 64'(ready), 64'd1);
      check_val($sformatf("cfg%0d_%s_valid", g, name), 64'(out_valid), 64'd0);
      for (int i = 0; i < NN; i++)
        check_val($sformatf("cfg%0d_%s_out[%0d]", g, name, i), 64'(res[i*32 +: 32]), 64'd0);
    endtask

    task automatic init_check();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_cleared("reset");
    endtask

    // flags: 0 mid-job start pulse with altered inputs, 1 hold ack off 10
    // cycles, 2 start together with ack, 3 reset during the second MAC
    task automatic run_job(input logic [3:0] flags);
      int cnt;
      check_val($sformatf("cfg%0d_ready_pre", g), 64'(ready), 64'd1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0;
      check_val($sformatf("cfg%0d_accept_ready", g), 64'(ready), 64'd0);
      while (!out_valid && cnt < 100) begin
        if (flags[0] && cnt == 1) begin
          start = 1'b1;
          ma = ~ma;
          mb = ~mb;
        end
        if (flags[3] && cnt == 2) reset = 1'b1;
        @(posedge clk); #1;
        cnt++;
        start = 1'b0;
        if (reset) begin
          reset = 1'b0;
          check_cleared("abort");
          return;
        end
        if (!out_valid)
          check_val($sformatf("cfg%0d_busy_ready", g), 64'(ready), 64'd0);
      end
      check_val($sformatf("cfg%0d_latency", g), 64'(cnt), 64'(2 * S));
      check_result("out");
      if (flags[1]) begin
        for (int t = 0; t < 10; t++) begin
          @(posedge clk); #1;
          check_val($sformatf("cfg%0d_hold_valid", g), 64'(out_valid), 64'd1);
          check_result("hold");
        end
      end
      out_ack = 1'b1;
      if (flags[2]) start = 1'b1;
      @(posedge clk); #1;
      out_ack = 1'b0;
      start   = 1'b0;
      check_val($sformatf("cfg%0d_ack_ready", g), 64'(ready), 64'd1);
      check_val($sformatf("cfg%0d_ack_valid", g), 64'(out_valid), 64'd0);
      if (flags[2]) begin
        @(posedge clk); #1;
        check_val($sformatf("cfg%0d_no_queue_ready", g), 64'(ready), 64'd1);
      end
    endtask

    task automatic random_jobs(input int reps);
      for (int j = 0; j < reps; j++) begin
        set_mats(0);
        run_job(4'b0000);
      end
    endtask
  end

  initial begin
    @(posedge clk); #1;
    cfg[0].init_check();
    cfg[1].init_check();
    cfg[2].init_check();
    cfg[3].init_check();
    cfg[4].init_check();

    cfg[0].set_mats(3); cfg[0].run_job(4'b0000);
    cfg[1].set_mats(2); cfg[1].run_job(4'b0000);
    cfg[2].set_mats(4); cfg[2].run_job(4'b0000);
    cfg[1].set_mats(0); cfg[1].run_job(4'b0111);
    cfg[1].set_mats(0); cfg[1].run_job(4'b1000);
    cfg[1].set_mats(0); cfg[1].run_job(4'b0000);
    cfg[4].set_mats(0); cfg[4].run_job(4'b1000);

    cfg[0].random_jobs(20);
    cfg[1].random_jobs(20);
    cfg[2].random_jobs(20);
    cfg[3].random_jobs(200);
    cfg[4].random_jobs(200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d",
             n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
